// File: rtl/array_access_fsm.sv
// Memory-instruction sequencer for array index (a <- (b)[c]) and array amend ((a)[b] <- c).
// Reads operands through the register unit, drives one memory access, and optionally writes back.
module array_access_fsm #(
    parameter int DATA_W    = 32,
    parameter int REG_SEL_W = 3,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 r,
    input  logic                 start,
    input  logic                 op,
    input  logic [REG_SEL_W-1:0] reg_a,
    input  logic [REG_SEL_W-1:0] reg_b,
    input  logic [REG_SEL_W-1:0] reg_c,
    input  logic [DATA_W-1:0]    reg_out_bus,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 reg_wr_en,
    output logic [DATA_W-1:0]    reg_wr_data,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_offset,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic                 mem_ready,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The access times out on the TIMEOUT-th consecutive cycle without ready.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        IDLE, SEL0, SEL1, SEL2, LAT, MEM, WB, DONE, ERR
    } state_t;

    state_t                 state_reg, state_next;
    logic                   op_reg;
    logic [REG_SEL_W-1:0]   a_reg, b_reg, c_reg;
    logic [DATA_W-1:0]      addr_reg, offset_reg, wdata_reg, rdata_reg;
    logic [CNT_W-1:0]       wait_reg;
    logic                   accept;
    logic                   timeout_hit;

    assign accept = start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);
    assign timeout_hit = (TIMEOUT > 0) && (wait_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SEL0;
            ERR:     if (start) state_next = SEL0;
            DONE:    state_next = start ? SEL0 : IDLE;
            SEL0:    state_next = SEL1;
            SEL1:    state_next = op_reg ? SEL2 : LAT;
            SEL2:    state_next = LAT;
            LAT:     state_next = MEM;
            MEM: begin
                if (mem_ready)
                    state_next = op_reg ? DONE : WB;
                else if (timeout_hit)
                    state_next = ERR;
            end
            WB:      state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Operand order: index reads B then C; amend reads A, B, then C.
    always_comb begin
        reg_sel     = '0;
        reg_wr_en   = 1'b0;
        reg_wr_data = '0;
        case (state_reg)
            SEL0: reg_sel = op_reg ? a_reg : b_reg;
            SEL1: reg_sel = op_reg ? b_reg : c_reg;
            SEL2: reg_sel = c_reg;
            WB: begin
                reg_sel     = a_reg;
                reg_wr_en   = 1'b1;
                reg_wr_data = rdata_reg;
            end
            default: ;
        endcase
    end

    assign mem_req    = (state_reg == MEM);
    assign mem_we     = (state_reg == MEM) && op_reg;
    assign mem_addr   = addr_reg;
    assign mem_offset = offset_reg;
    assign mem_wdata  = wdata_reg;
    assign busy       = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERR);
    assign done       = (state_reg == DONE);
    assign err        = (state_reg == ERR);

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_reg  <= IDLE;
            op_reg     <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            addr_reg   <= '0;
            offset_reg <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            wait_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg   <= op;
                a_reg    <= reg_a;
                b_reg    <= reg_b;
                c_reg    <= reg_c;
                wait_reg <= '0;
            end
            // reg_out_bus carries the register selected in the previous state.
            case (state_reg)
                SEL1: addr_reg <= reg_out_bus;
                SEL2: offset_reg <= reg_out_bus;
                LAT: begin
                    if (op_reg)
                        wdata_reg <= reg_out_bus;
                    else
                        offset_reg <= reg_out_bus;
                end
                MEM: begin
                    if (mem_ready) begin
                        if (!op_reg)
                            rdata_reg <= mem_rdata;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_array_access_fsm.sv
// Directed bench for array_access_fsm at DATA_W=64, REG_SEL_W=4: vector table plus
// hand sequences for mid-operation reset and back-to-back starts.
module tb_array_access_fsm;

    localparam int DW = 64;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          r;
    logic          start, op;
    logic [SW-1:0] reg_a, reg_b, reg_c, reg_sel;
    logic [DW-1:0] reg_out_bus, reg_wr_data;
    logic          reg_wr_en, mem_req, mem_we, mem_ready, busy, done, err;
    logic [DW-1:0] mem_addr, mem_offset, mem_wdata, mem_rdata;

    logic [DW-1:0] regs [16];

    int total = 0;
    int bad   = 0;

    array_access_fsm #(.DATA_W(DW), .REG_SEL_W(SW), .TIMEOUT(15)) dut (
        .clk(clk), .r(r), .start(start), .op(op),
        .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c),
        .reg_out_bus(reg_out_bus), .reg_sel(reg_sel),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_offset(mem_offset), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Register unit: read data appears the cycle after reg_sel.
    always @(posedge clk) reg_out_bus <= regs[reg_sel];

    typedef struct {
        logic          op;
        logic [SW-1:0] a, b, c;
        int            waits;
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_addr, exp_off, exp_wdata;
        int            exp_req;
        int            exp_wr;
        logic [SW-1:0] exp_wr_sel;
        logic [DW-1:0] exp_wr_data;
        int            exp_end;
        logic          exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc, req, wr;
        logic we_seen, done_seen, rdy;
        logic [DW-1:0] addr_seen, off_seen, wdata_seen, wr_data_seen;
        logic [SW-1:0] wr_sel_seen;
        req = 0; wr = 0; we_seen = 0; done_seen = 0;
        addr_seen = '0; off_seen = '0; wdata_seen = '0; wr_data_seen = '0; wr_sel_seen = '0;
        op = v.op; reg_a = v.a; reg_b = v.b; reg_c = v.c;
        mem_ready = (v.waits == 0);
        mem_rdata = ~v.rdata;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (mem_req) begin
                req++;
                we_seen = mem_we; addr_seen = mem_addr;
                off_seen = mem_offset; wdata_seen = mem_wdata;
            end
            if (reg_wr_en) begin
                wr++;
                wr_sel_seen = reg_sel; wr_data_seen = reg_wr_data;
            end
            if (done) done_seen = 1'b1;
            if (done || err) break;
            rdy = mem_req ? (req > v.waits) : (v.waits == 0);
            mem_ready = rdy;
            mem_rdata = rdy ? v.rdata : ~v.rdata;
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        $display("vec %0d op=%0d end=%0d req=%0d wr=%0d err=%0d", idx, v.op, cyc, req, wr, err);
        chk($sformatf("v%0d end_cycle", idx), 64'(cyc), 64'(v.exp_end));
        chk($sformatf("v%0d err", idx), 64'(err), 64'(v.exp_err));
        chk($sformatf("v%0d done", idx), 64'(done_seen), 64'(!v.exp_err));
        chk($sformatf("v%0d req_cycles", idx), 64'(req), 64'(v.exp_req));
        chk($sformatf("v%0d mem_we", idx), 64'(we_seen), 64'(v.op));
        chk($sformatf("v%0d mem_addr", idx), addr_seen, v.exp_addr);
        chk($sformatf("v%0d mem_offset", idx), off_seen, v.exp_off);
        if (v.op)
            chk($sformatf("v%0d mem_wdata", idx), wdata_seen, v.exp_wdata);
        chk($sformatf("v%0d wr_count", idx), 64'(wr), 64'(v.exp_wr));
        if (v.exp_wr != 0) begin
            chk($sformatf("v%0d wr_sel", idx), 64'(wr_sel_seen), 64'(v.exp_wr_sel));
            chk($sformatf("v%0d wr_data", idx), wr_data_seen, v.exp_wr_data);
        end
    endtask

    localparam logic [DW-1:0] R6  = 64'hFEDC_BA98_7654_3210;
    localparam logic [DW-1:0] R15 = 64'h8000_0000_0000_0001;

    initial begin : main
        int cyc, d1, d2, wr_n;
        logic [SW-1:0] s1, s2;
        logic [DW-1:0] a1, a2, o2;
        logic busy7, busy6;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        regs[1] = 64'd4; regs[2] = 64'd5; regs[3] = 64'd7; regs[4] = 64'd9;
        regs[5] = 64'h1234; regs[6] = R6; regs[15] = R15;

        //          op  a  b  c  waits rdata                   addr   off    wdata  req wr sel data                   end err
        vecs[0] = '{1'b0, 1, 2, 3, 0,  64'hDEADBEEF,           64'd5, 64'd7, 64'd0, 1,  1, 1,  64'hDEADBEEF,          6,  1'b0};
        vecs[1] = '{1'b1, 1, 4, 5, 3,  64'd0,                  64'd4, 64'd9, 64'h1234, 4, 0, 0, 64'd0,               9,  1'b0};
        vecs[2] = '{1'b0, 15, 6, 15, 1, 64'hA5A5_0000_FFFF_1234, R6,  R15,   64'd0, 2,  1, 15, 64'hA5A5_0000_FFFF_1234, 7, 1'b0};
        vecs[3] = '{1'b1, 15, 6, 15, 0, 64'd0,                 R15,   R6,    R15,   1,  0, 0,  64'd0,                 6,  1'b0};
        vecs[4] = '{1'b0, 2, 2, 2, 2,  64'h0123_4567_89AB_CDEF, 64'd5, 64'd5, 64'd0, 3,  1, 2,  64'h0123_4567_89AB_CDEF, 8, 1'b0};
        vecs[5] = '{1'b0, 1, 2, 3, 99, 64'd0,                  64'd5, 64'd7, 64'd0, 15, 0, 0,  64'd0,                 19, 1'b1};
        vecs[6] = '{1'b1, 1, 4, 5, 0,  64'd0,                  64'd4, 64'd9, 64'h1234, 1, 0, 0, 64'd0,               6,  1'b0};

        r = 1'b0; start = 1'b0; op = 1'b0; reg_a = '0; reg_b = '0; reg_c = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst mem_req", 64'(mem_req), 64'd0);
        chk("rst mem_addr", mem_addr, 64'd0);
        chk("rst err_done", 64'({err, done, reg_wr_en}), 64'd0);
        r = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            if (i == 5) begin
                @(posedge clk); #1;
                chk("err held", 64'(err), 64'd1);
                chk("err busy", 64'(busy), 64'd0);
                chk("err mem_req", 64'(mem_req), 64'd0);
            end
        end
        @(posedge clk); #1;

        // Reset during MEM: outputs drop without a clock edge.
        op = 1'b1; reg_a = 4'd1; reg_b = 4'd4; reg_c = 4'd5; mem_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc < 10 && !mem_req; cyc++) begin
            @(posedge clk); #1;
        end
        chk("midrst reached MEM", 64'(mem_req), 64'd1);
        #2 r = 1'b0;
        #1;
        $display("midrst reset applied at cycle %0d", cyc);
        chk("midrst mem_req", 64'(mem_req), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst mem_wdata", mem_wdata, 64'd0);
        @(posedge clk); #1;
        r = 1'b1;
        @(posedge clk); #1;
        chk("midrst idle", 64'({busy, done, err}), 64'd0);
        run_vec(7, vecs[0]);
        @(posedge clk); #1;

        // Start held high: second op begins in DONE; operand changes mid-op are ignored.
        op = 1'b0; reg_a = 4'd1; reg_b = 4'd2; reg_c = 4'd3;
        mem_ready = 1'b1; mem_rdata = 64'h1111;
        d1 = 0; d2 = 0; wr_n = 0; s1 = '0; s2 = '0; a1 = '0; a2 = '0; o2 = '0;
        busy6 = 1'b1; busy7 = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        for (cyc = 1; cyc <= 14; cyc++) begin
            if (cyc == 2) begin reg_a = 4'd4; reg_b = 4'd5; reg_c = 4'd6; end
            if (cyc == 7) start = 1'b0;
            if (done) begin
                if (d1 == 0) d1 = cyc; else if (d2 == 0) d2 = cyc;
            end
            if (cyc == 6) busy6 = busy;
            if (cyc == 7) busy7 = busy;
            if (cyc == 4) a1 = mem_addr;
            if (cyc == 10) begin a2 = mem_addr; o2 = mem_offset; end
            if (reg_wr_en) begin
                wr_n++;
                if (wr_n == 1) s1 = reg_sel; else s2 = reg_sel;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        $display("b2b done1=%0d done2=%0d writes=%0d sel1=%0d sel2=%0d", d1, d2, wr_n, s1, s2);
        chk("b2b done1 cycle", 64'(d1), 64'd6);
        chk("b2b done2 cycle", 64'(d2), 64'd12);
        chk("b2b busy in DONE", 64'(busy6), 64'd0);
        chk("b2b busy after DONE", 64'(busy7), 64'd1);
        chk("b2b op1 addr", a1, 64'd5);
        chk("b2b op2 addr", a2, 64'h1234);
        chk("b2b op2 offset", o2, R6);
        chk("b2b writes", 64'(wr_n), 64'd2);
        chk("b2b op1 wr_sel", 64'(s1), 64'd1);
        chk("b2b op2 wr_sel", 64'(s2), 64'd4);
        chk("b2b idle", 64'({busy, done}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/array_access_fsm.md
Name: array_access_fsm

Overview:
- Parametrised memory-instruction sequencer for the control unit.
- Executes array index (op 0001, a <- (b)[c]) and array amend (op 0010, (a)[b] <- c) under one FSM.
- Sits between the control-unit dispatcher, the register unit and the memory unit.
- Adds, relative to the fixed-width per-op sequencers: generic widths, a start/done handshake, a memory request/ready handshake with wait states, and a timeout error.

Parameters:
- DATA_W, 32, width of register data, array id, offset and memory data.
- REG_SEL_W, 3, width of register select.
- TIMEOUT, 15, maximum mem_req cycles without mem_ready before error; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge
- r  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE, DONE or ERR
- op  in  1  0 = index, 1 = amend
- reg_a, reg_b, reg_c  in  REG_SEL_W  instruction register fields
- reg_out_bus  in  DATA_W  register read data; valid the cycle after reg_sel presented
- reg_sel  out  REG_SEL_W  register select
- reg_wr_en  out  1  register write strobe
- reg_wr_data  out  DATA_W  register write data
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (amend), 0 = read (index)
- mem_addr  out  DATA_W  array id
- mem_offset  out  DATA_W  array offset
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory completion, sampled while mem_req = 1
- mem_rdata  in  DATA_W  read data, valid when mem_ready = 1
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  timeout flag

Behaviour:
- Reset (r = 0): all outputs and internal registers go to 0 asynchronously, state goes to IDLE. Takes effect mid-operation too: mem_req drops immediately and no write-back occurs.
- States: IDLE, SEL0, SEL1, SEL2, LAT, MEM, WB, DONE, ERR.
- IDLE/DONE/ERR with start = 1: latch op, reg_a, reg_b, reg_c; clear err; go to SEL0. start is ignored in all other states.
- Index sequence:
  - SEL0: reg_sel = B.
  - SEL1: reg_sel = C; latch mem_addr <= reg_out_bus.
  - LAT: latch mem_offset <= reg_out_bus.
  - MEM.
  - WB: reg_wr_en = 1, reg_sel = A, reg_wr_data = latched read data.
  - DONE.
- Amend sequence:
  - SEL0: reg_sel = A.
  - SEL1: reg_sel = B; latch mem_addr.
  - SEL2: reg_sel = C; latch mem_offset.
  - LAT: latch mem_wdata.
  - MEM.
  - DONE (no WB).
- MEM state:
  - mem_req = 1, mem_we = op; mem_addr, mem_offset and mem_wdata are held stable.
  - mem_ready = 1 at a rising edge completes the access; index captures mem_rdata on that edge. Zero-wait is legal (ready in the first MEM cycle).
  - Wait counter (width clog2(TIMEOUT+1)) increments for each MEM cycle without ready.
  - Timeout: if TIMEOUT > 0 and the counter reaches TIMEOUT while mem_ready = 0, go to ERR.
  - mem_ready outside MEM is ignored.
- ERR: err = 1 and held, busy = 0, done = 0, no register write; leave only on start or reset.
- DONE: done = 1 for exactly one cycle, then IDLE. A start in DONE is accepted and goes straight to SEL0 (back-to-back).
- busy = 1 in SEL0..WB; 0 in IDLE, DONE, ERR.
- reg_sel = 0 and reg_wr_en = 0 in IDLE, DONE, ERR.
- Latency with zero wait states: done asserted in the 6th cycle after the start edge for both ops. Each wait cycle adds 1.
- Operand registers are captured at start, so later changes to reg_a/b/c do not affect an in-flight operation.
- Same register used for several fields (e.g. A = B): behaviour is defined by the sequence order above. Operands are read before any write.

Test Plan:
- Index, zero wait: R2 = 5, R3 = 7, reg_a = 1, reg_b = 2, reg_c = 3, mem_ready tied 1, mem_rdata = 0xDEADBEEF -> mem_addr = 5, mem_offset = 7, mem_we = 0; reg_wr_en pulse with reg_sel = 1, data 0xDEADBEEF; done in cycle 6.
- Amend, 3 wait states: R1 = 4, R2 = 9, R3 = 0x1234 -> mem_req high 4 cycles with mem_addr = 4, mem_offset = 9, mem_wdata = 0x1234, mem_we = 1; no reg_wr_en; done in cycle 9.
- Timeout: TIMEOUT = 15, mem_ready held 0 -> ERR after 15 MEM cycles; err = 1, mem_req = 0, done never pulses. A new start clears err and completes normally.
- Mid-op reset: assert r = 0 during MEM -> mem_req, busy, reg_wr_en drop without a clock edge; after release, state is IDLE and a new start completes.
- Back-to-back and ignored start: start asserted every cycle -> the second op begins in the DONE cycle; starts during busy have no effect; latched operands unchanged when reg_a/b/c toggle mid-op.
- Parametrisation: DATA_W = 64, REG_SEL_W = 4, reg_a = 15 -> 64-bit values pass unmodified; reg_sel reaches 15.
